aui_lane_deskew: RTL

Receive-side lane deskew for the 16-lane AUI path. It accepts per-lane words and per-lane alignment-marker flags in the same shape the AUI generator drives. It buffers each lane in a small FIFO, locks when every lane has presented its marker, and then releases all lanes word-aligned to the marker. It sits between the lane interface and the AUI checker, so the checker sees zero inter-lane skew.

---
 rtl/aui_lane_deskew.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/aui_lane_deskew.sv
// Receive-side lane deskew: per-lane {sync, word} FIFOs fill from each lane's
// alignment marker, lock once every lane has its marker, then drain in lock-step.
module aui_lane_deskew #(
  parameter int NUMBER_LANES = 16,
  parameter int LANE_WIDTH   = 1360,
  parameter int MAX_SKEW     = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUMBER_LANES*LANE_WIDTH-1:0]   i_lanes,
  input  logic [NUMBER_LANES-1:0]              i_sync,
  input  logic                                 i_valid,
  output logic [NUMBER_LANES*LANE_WIDTH-1:0]   o_lanes,
  output logic                                 o_valid,
  output logic                                 o_marker,
  output logic                                 o_aligned,
  output logic                                 o_skew_err,
  output logic [$clog2(MAX_SKEW)-1:0]          o_max_skew
);

  localparam int PW = $clog2(MAX_SKEW);
  localparam int CW = PW + 1;

  typedef enum logic {SEARCH = 1'b0, ALIGNED = 1'b1} state_t;

  state_t                            r_state;
  state_t                            w_next_state;
  logic [NUMBER_LANES-1:0]           r_captured;
  logic [NUMBER_LANES-1:0]           w_captured_nxt;
  logic [NUMBER_LANES-1:0]           w_wr_en;
  logic [NUMBER_LANES-1:0]           w_full;
  logic [NUMBER_LANES-1:0]           w_head_sync;
  logic [NUMBER_LANES*CW-1:0]        w_count;
  logic [NUMBER_LANES*LANE_WIDTH-1:0] w_heads;
  logic [CW-1:0]                     w_max_cnt;
  logic                              w_pop;
  logic                              w_lock;
  logic                              w_err;

  // Handshake: i_valid qualifies every lane's word in the same cycle; there is
  // no backpressure, and o_valid qualifies o_lanes/o_marker for one cycle.

  for (genvar g = 0; g < NUMBER_LANES; g++) begin : g_lane
    logic [LANE_WIDTH:0] r_mem [MAX_SKEW];
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;

    always_ff @(posedge clk) begin
      if (w_wr_en[g]) r_mem[r_wr_ptr] <= {i_sync[g], i_lanes[g*LANE_WIDTH +: LANE_WIDTH]};
    end

    // An error flushes the lane by collapsing the pointers; contents are left stale.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else if (w_err) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_wr_en[g]) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)      r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count <= r_count + CW'(w_wr_en[g]) - CW'(w_pop);
      end
    end

    assign w_count[g*CW +: CW]                    = r_count;
    assign w_full[g]                              = (r_count == CW'(MAX_SKEW));
    assign w_head_sync[g]                         = r_mem[r_rd_ptr][LANE_WIDTH];
    assign w_heads[g*LANE_WIDTH +: LANE_WIDTH]    = r_mem[r_rd_ptr][LANE_WIDTH-1:0];
  end

  // Per-lane write enables, post-write capture flags and the largest post-write count.
  always_comb begin
    w_wr_en        = '0;
    w_captured_nxt = r_captured;
    w_max_cnt      = '0;
    for (int k = 0; k < NUMBER_LANES; k++) begin
      if (i_valid) begin
        if (r_state == ALIGNED) begin
          w_wr_en[k] = 1'b1;
        end else if (r_captured[k] || i_sync[k]) begin
          w_wr_en[k]        = 1'b1;
          w_captured_nxt[k] = 1'b1;
        end
      end
      if (w_count[k*CW +: CW] + CW'(w_wr_en[k]) > w_max_cnt)
        w_max_cnt = w_count[k*CW +: CW] + CW'(w_wr_en[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= SEARCH;
      r_captured <= '0;
    end else begin
      r_state    <= w_next_state;
      r_captured <= w_err ? '0 : w_captured_nxt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      SEARCH:  if (w_lock) w_next_state = ALIGNED;
      ALIGNED: if (w_err)  w_next_state = SEARCH;
      default: w_next_state = SEARCH;
    endcase
  end

  // A full captured lane that must take another word is an error even on the lock cycle.
  always_comb begin
    w_pop  = 1'b0;
    w_lock = 1'b0;
    w_err  = 1'b0;
    case (r_state)
      SEARCH: begin
        w_err  = i_valid && (|(r_captured & w_full));
        w_lock = i_valid && (&w_captured_nxt) && !w_err;
      end
      ALIGNED: begin
        w_pop = i_valid;
        w_err = i_valid && (|w_head_sync) && !(&w_head_sync);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_lanes    <= '0;
      o_valid    <= 1'b0;
      o_marker   <= 1'b0;
      o_skew_err <= 1'b0;
      o_max_skew <= '0;
    end else begin
      o_skew_err <= w_err;
      o_valid    <= w_pop && !w_err;
      o_marker   <= w_pop && !w_err && (&w_head_sync);
      if (w_pop && !w_err) o_lanes <= w_heads;
      if (w_lock) o_max_skew <= PW'(w_max_cnt - CW'(1));
    end
  end

  assign o_aligned = (r_state == ALIGNED);

endmodule
